// File: rtl/display_mux_rtc_6dig_pkg.sv
// Shared constants for the RTC display path.
// Field select codes match those used by the BCD counters.
package display_mux_rtc_6dig_pkg;

    localparam logic [3:0] FIELD_SEC = 4'd8;
    localparam logic [3:0] FIELD_MIN = 4'd9;
    localparam logic [3:0] FIELD_HR  = 4'd10;

    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_DASH  = 7'b0111111;

    localparam int NUM_DIGITS = 6;

endpackage

// File: rtl/display_mux_rtc_6dig_bcd_to_7seg.sv
// BCD to active-low 7-segment decoder, {g,f,e,d,c,b,a}.
// Non-BCD codes show a dash.
module bcd_to_7seg
    import display_mux_rtc_6dig_pkg::*;
(
    input  logic [3:0] i_bcd,
    output logic [6:0] o_seg
);

    always_comb begin
        o_seg = SEG_DASH;
        case (i_bcd)
            4'd0: o_seg = 7'b1000000;
            4'd1: o_seg = 7'b1111001;
            4'd2: o_seg = 7'b0100100;
            4'd3: o_seg = 7'b0110000;
            4'd4: o_seg = 7'b0011001;
            4'd5: o_seg = 7'b0010010;
            4'd6: o_seg = 7'b0000010;
            4'd7: o_seg = 7'b1111000;
            4'd8: o_seg = 7'b0000000;
            4'd9: o_seg = 7'b0010000;
            default: o_seg = SEG_DASH;
        endcase
    end

endmodule

// File: rtl/display_mux_rtc_6dig.sv
// Six-digit hh.mm.ss multiplexer for an 8-digit common-anode display,
// with blinking of the field currently being edited.
module display_mux_rtc_6dig
    import display_mux_rtc_6dig_pkg::*;
#(
    parameter int REFRESH_CNT = 100000,
    parameter int BLINK_CNT   = 25000000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] en_count,
    input  logic [3:0] sec_d1,
    input  logic [3:0] sec_d0,
    input  logic [3:0] min_d1,
    input  logic [3:0] min_d0,
    input  logic [3:0] hr_d1,
    input  logic [3:0] hr_d0,
    output logic [7:0] an,
    output logic [6:0] seg,
    output logic       dp
);

    localparam int RW = (REFRESH_CNT > 2) ? $clog2(REFRESH_CNT) : 1;
    localparam int BW = (BLINK_CNT > 2) ? $clog2(BLINK_CNT) : 1;

    logic [RW-1:0] r_refresh_cnt;
    logic [2:0]    r_scan_idx;
    logic [BW-1:0] r_blink_cnt;
    logic          r_blink_phase;
    logic [3:0]    r_en_prev;
    logic [7:0]    r_an;
    logic [6:0]    r_seg;
    logic          r_dp;

    logic [3:0] w_digit;
    logic [3:0] w_field;
    logic [6:0] w_seg;
    logic       w_en_chg;
    logic       w_phase;
    logic       w_blank;
    logic       w_ref_wrap;
    logic       w_blk_wrap;

    always_comb begin
        w_digit = 4'd0;
        w_field = FIELD_SEC;
        case (r_scan_idx)
            3'd0: begin w_digit = sec_d0; w_field = FIELD_SEC; end
            3'd1: begin w_digit = sec_d1; w_field = FIELD_SEC; end
            3'd2: begin w_digit = min_d0; w_field = FIELD_MIN; end
            3'd3: begin w_digit = min_d1; w_field = FIELD_MIN; end
            3'd4: begin w_digit = hr_d0;  w_field = FIELD_HR;  end
            3'd5: begin w_digit = hr_d1;  w_field = FIELD_HR;  end
            default: begin w_digit = 4'd0; w_field = FIELD_SEC; end
        endcase
    end

    bcd_to_7seg u_dec (
        .i_bcd (w_digit),
        .o_seg (w_seg)
    );

    // A field change forces visibility on the very edge it is seen
    assign w_en_chg   = (en_count != r_en_prev);
    assign w_phase    = w_en_chg | r_blink_phase;
    assign w_blank    = (en_count == w_field) && !w_phase;
    assign w_ref_wrap = (r_refresh_cnt == RW'(REFRESH_CNT - 1));
    assign w_blk_wrap = (r_blink_cnt == BW'(BLINK_CNT - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            r_refresh_cnt <= '0;
            r_scan_idx    <= 3'd0;
            r_blink_cnt   <= '0;
            r_blink_phase <= 1'b1;
            r_en_prev     <= 4'd0;
            r_an          <= 8'hFF;
            r_seg         <= SEG_BLANK;
            r_dp          <= 1'b1;
        end else begin
            r_en_prev <= en_count;

            if (w_ref_wrap) begin
                r_refresh_cnt <= '0;
                r_scan_idx    <= (r_scan_idx == 3'(NUM_DIGITS - 1)) ?
                                 3'd0 : r_scan_idx + 3'd1;
            end else begin
                r_refresh_cnt <= r_refresh_cnt + RW'(1);
            end

            if (w_en_chg) begin
                r_blink_cnt   <= '0;
                r_blink_phase <= 1'b1;
            end else if (w_blk_wrap) begin
                r_blink_cnt   <= '0;
                r_blink_phase <= ~r_blink_phase;
            end else begin
                r_blink_cnt   <= r_blink_cnt + BW'(1);
            end

            r_an  <= w_blank ? 8'hFF : ~(8'd1 << r_scan_idx);
            r_seg <= w_blank ? SEG_BLANK : w_seg;
            r_dp  <= !((r_scan_idx == 3'd2) || (r_scan_idx == 3'd4));
        end
    end

    assign an  = r_an;
    assign seg = r_seg;
    assign dp  = r_dp;

endmodule
